// File: rtl/systolic_tile_sequencer_if.sv
// Command, controller, weight-SRAM and status signals of the tile sequencer.
// slave is the sequencer's own view; master is the scheduler/controller/SRAM side.
interface systolic_tile_sequencer_if #(
  parameter int WT_ADDR_WIDTH = 12,
  parameter int TILE_W        = 8
);
  logic                     cmd_valid;
  logic                     cmd_ready;
  logic [TILE_W-1:0]        cmd_num_tiles;
  logic [WT_ADDR_WIDTH-1:0] cmd_wt_base;
  logic                     load_weight;
  logic                     valid_in;
  logic                     ctrl_ready;
  logic                     ctrl_busy;
  logic                     ctrl_done;
  logic                     wt_rd_en;
  logic [WT_ADDR_WIDTH-1:0] wt_rd_addr;
  logic [TILE_W-1:0]        tile_idx;
  logic                     tile_done;
  logic                     job_done;
  logic                     busy;
  logic                     err_timeout;

  modport slave (
    input  cmd_valid, cmd_num_tiles, cmd_wt_base, ctrl_ready, ctrl_busy, ctrl_done,
    output cmd_ready, load_weight, valid_in, wt_rd_en, wt_rd_addr,
           tile_idx, tile_done, job_done, busy, err_timeout
  );

  modport master (
    output cmd_valid, cmd_num_tiles, cmd_wt_base, ctrl_ready, ctrl_busy, ctrl_done,
    input  cmd_ready, load_weight, valid_in, wt_rd_en, wt_rd_addr,
           tile_idx, tile_done, job_done, busy, err_timeout
  );
endinterface

// File: rtl/systolic_tile_sequencer.sv
// Tile-job sequencer for systolic_controller: per tile loads N_SIZE weight rows, then runs the compute window.
// SEQ_WATCHDOG_EN adds a ctrl_done timeout in WAIT_DONE with a sticky err_timeout.
module systolic_tile_sequencer #(
  parameter int N_SIZE        = 32,
  parameter int NUM_ROWS      = 512,
  parameter int WT_ADDR_WIDTH = 12,
  parameter int TILE_W        = 8
`ifdef SEQ_WATCHDOG_EN
  , parameter int WDOG_CYCLES = 4096
`endif
) (
  input logic                      clk,
  input logic                      rst,
  systolic_tile_sequencer_if.slave sq
);
  localparam int COMP_LEN = NUM_ROWS + 2 * N_SIZE - 1;
  localparam int CNT_W    = $clog2(COMP_LEN + 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_SETTLE    = 3'd1;
  localparam logic [2:0] S_WAIT_RDY  = 3'd2;
  localparam logic [2:0] S_LOAD_W    = 3'd3;
  localparam logic [2:0] S_COMPUTE   = 3'd4;
  localparam logic [2:0] S_WAIT_DONE = 3'd5;

  logic [2:0]               state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     loaded_q, loaded_d;
  logic [WT_ADDR_WIDTH-1:0] base_q, base_d;
  logic [WT_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WT_ADDR_WIDTH-1:0] tile_base;
  logic [TILE_W-1:0]        ntiles_q, ntiles_d;
  logic [TILE_W-1:0]        tile_idx_q, tile_idx_d;
  logic                     tile_done_q, tile_done_d;
  logic                     job_done_q, job_done_d;
  logic                     load_q, valid_q, ready_q, busy_q;
`ifdef SEQ_WATCHDOG_EN
  localparam int WD_W = $clog2(WDOG_CYCLES + 1);
  logic [WD_W-1:0]          wd_q, wd_d;
  logic                     err_q, err_d;
`endif

  // Address arithmetic deliberately wraps at the SRAM address width.
  assign tile_base = base_q + WT_ADDR_WIDTH'(tile_idx_q) * WT_ADDR_WIDTH'(N_SIZE);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    loaded_d    = loaded_q;
    base_d      = base_q;
    addr_d      = addr_q;
    ntiles_d    = ntiles_q;
    tile_idx_d  = tile_idx_q;
    tile_done_d = 1'b0;
    job_done_d  = 1'b0;
`ifdef SEQ_WATCHDOG_EN
    wd_d        = '0;
    err_d       = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (sq.cmd_valid) begin
          base_d     = sq.cmd_wt_base;
          ntiles_d   = sq.cmd_num_tiles;
          tile_idx_d = '0;
          loaded_d   = 1'b0;
          cnt_d      = '0;
          if (sq.cmd_num_tiles == '0) job_done_d = 1'b1;
          else                        state_d    = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_WAIT_RDY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WAIT_RDY: begin
        if (sq.ctrl_ready && !sq.ctrl_busy) begin
          cnt_d = '0;
          if (!loaded_q) begin
            state_d = S_LOAD_W;
            addr_d  = tile_base;
          end else begin
            state_d = S_COMPUTE;
          end
        end
      end
      S_LOAD_W: begin
        if (cnt_q == CNT_W'(N_SIZE - 1)) begin
          state_d  = S_SETTLE;
          cnt_d    = '0;
          loaded_d = 1'b1;
          addr_d   = '0;
        end else begin
          cnt_d  = cnt_q + CNT_W'(1);
          addr_d = addr_q + WT_ADDR_WIDTH'(1);
        end
      end
      S_COMPUTE: begin
        // valid_in drops before WAIT_DONE so the controller never sees it held into ctrl_done.
        if (cnt_q == CNT_W'(COMP_LEN - 1)) begin
          state_d = S_WAIT_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WAIT_DONE: begin
        if (sq.ctrl_done) begin
          tile_done_d = 1'b1;
          tile_idx_d  = tile_idx_q + TILE_W'(1);
          loaded_d    = 1'b0;
          if (tile_idx_q + TILE_W'(1) == ntiles_q) begin
            job_done_d = 1'b1;
            state_d    = S_IDLE;
          end else begin
            state_d = S_SETTLE;
          end
        end
`ifdef SEQ_WATCHDOG_EN
        else if (wd_q == WD_W'(WDOG_CYCLES - 1)) begin
          err_d      = 1'b1;
          job_done_d = 1'b1;
          state_d    = S_IDLE;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      loaded_q    <= 1'b0;
      base_q      <= '0;
      addr_q      <= '0;
      ntiles_q    <= '0;
      tile_idx_q  <= '0;
      tile_done_q <= 1'b0;
      job_done_q  <= 1'b0;
      load_q      <= 1'b0;
      valid_q     <= 1'b0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      loaded_q    <= loaded_d;
      base_q      <= base_d;
      addr_q      <= addr_d;
      ntiles_q    <= ntiles_d;
      tile_idx_q  <= tile_idx_d;
      tile_done_q <= tile_done_d;
      job_done_q  <= job_done_d;
      load_q      <= (state_d == S_LOAD_W);
      valid_q     <= (state_d == S_COMPUTE);
      ready_q     <= (state_d == S_IDLE);
      busy_q      <= (state_d != S_IDLE);
    end
  end

`ifdef SEQ_WATCHDOG_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end
  assign sq.err_timeout = err_q;
`else
  assign sq.err_timeout = 1'b0;
`endif

  assign sq.cmd_ready   = ready_q;
  assign sq.load_weight = load_q;
  assign sq.wt_rd_en    = load_q;
  assign sq.valid_in    = valid_q;
  assign sq.wt_rd_addr  = addr_q;
  assign sq.tile_idx    = tile_idx_q;
  assign sq.tile_done   = tile_done_q;
  assign sq.job_done    = job_done_q;
  assign sq.busy        = busy_q;
endmodule

// File: tb/tb_systolic_tile_sequencer.sv
// Bench for systolic_tile_sequencer with a behavioural controller + weight SRAM model.
// Define SEQ_WATCHDOG_EN to also exercise the ctrl_done timeout.
module tb_systolic_tile_sequencer;
  localparam int N     = 4;
  localparam int ROWS  = 8;
  localparam int AW    = 12;
  localparam int TW    = 8;
  localparam int WDOG  = 64;
  localparam int COMP  = ROWS + 2 * N - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  initial forever #5 clk = ~clk;

  systolic_tile_sequencer_if #(.WT_ADDR_WIDTH(AW), .TILE_W(TW)) sif ();

  systolic_tile_sequencer #(
    .N_SIZE(N), .NUM_ROWS(ROWS), .WT_ADDR_WIDTH(AW), .TILE_W(TW)
`ifdef SEQ_WATCHDOG_EN
    , .WDOG_CYCLES(WDOG)
`endif
  ) dut (
    .clk (clk),
    .rst (rst),
    .sq  (sif)
  );

  int checks = 0;
  int passed = 0;
  int fails  = 0;
  string job_name = "reset";

  // Controller / SRAM model
  logic        c_busy, c_ran, c_ready, c_done, ld_d1;
  int          c_dly;
  logic [1:0]  row_sel;
  logic [15:0] rd_data;
  logic [15:0] wrow [N];
  bit          no_done = 1'b0;

  assign sif.ctrl_ready = c_ready;
  assign sif.ctrl_busy  = c_busy;
  assign sif.ctrl_done  = c_done;

  function automatic logic [15:0] sram(input logic [AW-1:0] a);
    return {4'hA, a ^ 12'h5C3};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      c_busy <= 1'b0; c_ran <= 1'b0; c_dly <= 0; c_ready <= 1'b1; c_done <= 1'b0;
      ld_d1 <= 1'b0; row_sel <= '0; rd_data <= '0;
    end else begin
      c_done <= 1'b0;
      ld_d1  <= sif.load_weight;
      if (sif.wt_rd_en) rd_data <= sram(sif.wt_rd_addr);
      if (ld_d1) begin
        wrow[row_sel] <= rd_data;
        row_sel       <= row_sel + 2'd1;
      end else begin
        row_sel <= '0;
      end
      if (sif.load_weight || sif.valid_in) begin
        c_busy <= 1'b1;
        c_ran  <= sif.valid_in;
        c_dly  <= $urandom_range(0, 3);
        // stray done pulses around weight loading must be ignored
        if (sif.load_weight && $urandom_range(0, 3) == 0) c_done <= 1'b1;
      end else if (c_busy) begin
        if (!c_ran) c_busy <= 1'b0;
        else if (c_dly == 0) begin
          c_busy <= 1'b0; c_ran <= 1'b0; c_done <= !no_done;
        end else c_dly <= c_dly - 1;
      end
      c_ready <= !c_busy && ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor
  logic [AW-1:0] ld_addr [$];
  logic [TW-1:0] ld_tile [$];
  int lruns [$];
  int vruns [$];
  int lrun, vrun, overlap, rden_bad, td, jd;

  always @(negedge clk) begin
    if (!rst) begin
      if (sif.load_weight === 1'b1) begin
        ld_addr.push_back(sif.wt_rd_addr);
        ld_tile.push_back(sif.tile_idx);
        lrun++;
      end else if (lrun != 0) begin
        lruns.push_back(lrun); lrun = 0;
      end
      if (sif.valid_in === 1'b1) vrun++;
      else if (vrun != 0) begin
        vruns.push_back(vrun); vrun = 0;
      end
      if (sif.load_weight === 1'b1 && sif.valid_in === 1'b1) overlap++;
      if (sif.wt_rd_en !== sif.load_weight) rden_bad++;
      if (sif.tile_done === 1'b1) td++;
      if (sif.job_done === 1'b1) jd++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s/%s observed=%0h expected=%0h", job_name, tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    ld_addr.delete(); ld_tile.delete(); lruns.delete(); vruns.delete();
    lrun = 0; vrun = 0; overlap = 0; rden_bad = 0; td = 0; jd = 0;
  endtask

  task automatic issue(input logic [AW-1:0] base, input logic [TW-1:0] n);
    int k = 0;
    while (sif.cmd_ready !== 1'b1 && k < 200) begin tick(); k++; end
    check("cmd_ready_before_accept", sif.cmd_ready, 1);
    clear_mon();
    sif.cmd_valid = 1'b1; sif.cmd_wt_base = base; sif.cmd_num_tiles = n;
    tick();
    sif.cmd_valid = 1'b0; sif.cmd_wt_base = AW'($urandom); sif.cmd_num_tiles = TW'($urandom);
  endtask

  task automatic run_job(input logic [AW-1:0] base, input logic [TW-1:0] n);
    int k, bad, t, r;
    logic [AW-1:0] ea;
    issue(base, n);
    if (n == 0) begin
      check("zero_job_done_next_cycle", sif.job_done, 1);
      check("zero_cmd_ready", sif.cmd_ready, 1);
      check("zero_busy", sif.busy, 0);
    end else begin
      check("busy_after_accept", sif.busy, 1);
      check("cmd_ready_low_after_accept", sif.cmd_ready, 0);
      k = 0;
      while (sif.job_done !== 1'b1 && k < 4000) begin
        sif.cmd_valid = 1'($urandom_range(0, 1));
        tick(); k++;
      end
      sif.cmd_valid = 1'b0;
      check("job_done_seen", sif.job_done, 1);
      check("cmd_ready_at_job_done", sif.cmd_ready, 1);
    end
    tick();
    check("job_done_is_pulse", sif.job_done, 0);
    tick();
    check("job_done_count", jd, 1);
    check("tile_done_count", td, 32'(n));
    check("load_beats", ld_addr.size(), 32'(n) * N);
    check("load_bursts", lruns.size(), 32'(n));
    bad = 0;
    foreach (lruns[i]) if (lruns[i] != N) bad++;
    check("load_burst_len", bad, 0);
    bad = 0;
    for (int i = 0; i < ld_addr.size(); i++) begin
      t  = i / N; r = i % N;
      ea = base + AW'(t * N + r);
      if (ld_addr[i] !== ea || ld_tile[i] !== TW'(t)) bad++;
    end
    check("load_addr_tile_seq", bad, 0);
    if (ld_addr.size() > 0) check("first_load_addr", ld_addr[0], base);
    check("compute_windows", vruns.size(), 32'(n));
    bad = 0;
    foreach (vruns[i]) if (vruns[i] != COMP) bad++;
    check("compute_window_len", bad, 0);
    check("load_valid_overlap", overlap, 0);
    check("rd_en_tracks_load", rden_bad, 0);
    if (n > 0) begin
      bad = 0;
      for (int i = 0; i < N; i++)
        if (wrow[i] !== sram(base + AW'((32'(n) - 1) * N + i))) bad++;
      check("weight_row_align", bad, 0);
    end
  endtask

  initial begin
    int k, vcnt;
    sif.cmd_valid = 1'b0; sif.cmd_wt_base = '0; sif.cmd_num_tiles = '0;
    clear_mon();
    repeat (3) tick();
    check("rst_cmd_ready", sif.cmd_ready, 1);
    check("rst_busy", sif.busy, 0);
    check("rst_load_weight", sif.load_weight, 0);
    check("rst_valid_in", sif.valid_in, 0);
    check("rst_tile_idx", sif.tile_idx, 0);
    check("rst_err_timeout", sif.err_timeout, 0);
    rst = 1'b0;
    tick();

    job_name = "one_tile_0x010";  run_job(12'h010, 1);
    job_name = "three_tiles";     run_job(12'h100, 3);
    job_name = "zero_tiles";      run_job(12'h2A0, 0);
    job_name = "wrap_0xFFE";      run_job(12'hFFE, 1);
    for (int j = 0; j < 4; j++) begin
      job_name = $sformatf("random_%0d", j);
      run_job(AW'($urandom), TW'($urandom_range(1, 3)));
    end

    job_name = "reset_mid_compute";
    issue(12'h123, 1);
    k = 0; vcnt = 0;
    while (vcnt < 5 && k < 500) begin
      tick(); k++;
      if (sif.valid_in === 1'b1) vcnt++;
    end
    check("reached_compute", vcnt, 5);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_cmd_ready", sif.cmd_ready, 1);
    check("mid_rst_valid_in", sif.valid_in, 0);
    check("mid_rst_load_weight", sif.load_weight, 0);
    check("mid_rst_busy", sif.busy, 0);
    check("mid_rst_rd_addr", sif.wt_rd_addr, 0);
    check("mid_rst_tile_idx", sif.tile_idx, 0);
    check("mid_rst_job_done", sif.job_done, 0);
    tick(); tick();
    rst = 1'b0;
    tick();
    job_name = "after_reset";     run_job(12'h3C0, 2);

`ifdef SEQ_WATCHDOG_EN
    job_name = "watchdog";
    no_done = 1'b1;
    issue(12'h040, 1);
    k = 0;
    while (sif.valid_in !== 1'b1 && k < 500) begin tick(); k++; end
    while (sif.valid_in === 1'b1 && k < 1000) begin tick(); k++; end
    vcnt = 0;
    while (sif.job_done !== 1'b1 && vcnt < 1000) begin tick(); vcnt++; end
    check("wdog_wait_cycles", vcnt, WDOG);
    check("wdog_err_timeout", sif.err_timeout, 1);
    check("wdog_cmd_ready", sif.cmd_ready, 1);
    tick();
    check("wdog_err_sticky", sif.err_timeout, 1);
    check("wdog_no_tile_done", td, 0);
    no_done = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0; tick();
    check("wdog_err_cleared_by_rst", sif.err_timeout, 0);
`else
    check("err_timeout_tied_low", sif.err_timeout, 0);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
